// File: rtl/ysyx_22040125_axi_master.sv
// Single-beat AXI4 initiator: one CPU request in flight, mapped to AR/R or AW/W/B.
// Optional macro YSYX_22040125_AXI_RESP_CHK_EN enables rsp_err from rresp/rid and bresp/bid.
module ysyx_22040125_axi_master #(
  parameter logic [3:0] AXI_ID   = 4'd0,
  parameter logic [2:0] AXI_PROT = 3'b000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AWW, WR_B, RSP} state_t;

  state_t      state, state_nxt;
  logic        ready_en;
  logic        aw_done, w_done;
  logic        err_q;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;
  logic        accept;
  logic        aww_finish;

  assign accept     = (state == IDLE) && ready_en && req_valid;
  assign aww_finish = (aw_done || awready) && (w_done || wready);

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Keeps req_ready low while reset is held, even though the state is already IDLE.
  always_ff @(posedge aclk) begin
    if (!aresetn) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = ready_en;
        if (accept) state_nxt = req_wen ? WR_AWW : RD_AR;
      end
      RD_AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = RD_R;
      end
      RD_R: begin
        rready = 1'b1;
        if (rvalid) state_nxt = RSP;
      end
      WR_AWW: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if (aww_finish) state_nxt = WR_B;
      end
      WR_B: begin
        bready = 1'b1;
        if (bvalid) state_nxt = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      err_q     <= 1'b0;
      rsp_rdata <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
      if (state == WR_AWW) begin
        if (aww_finish) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else begin
          aw_done <= aw_done || (awvalid && awready);
          w_done  <= w_done  || (wvalid && wready);
        end
      end
      if (state == RD_R && rvalid) rsp_rdata <= rdata;
`ifdef YSYX_22040125_AXI_RESP_CHK_EN
      if (state == RD_R && rvalid)      err_q <= (rresp != 2'b00) || (rid != AXI_ID);
      else if (state == WR_B && bvalid) err_q <= (bresp != 2'b00) || (bid != AXI_ID);
      else if (state == RSP)            err_q <= 1'b0;
`else
      err_q <= 1'b0;
`endif
    end
  end

`ifdef YSYX_22040125_AXI_RESP_CHK_EN
  assign rsp_err = err_q;
  logic unused_ok;
  assign unused_ok = rlast;
`else
  assign rsp_err = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{rlast, rid, rresp, bid, bresp, err_q};
`endif

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = size_q;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = AXI_PROT;

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = size_q;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = AXI_PROT;

  assign wid     = AXI_ID;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;

endmodule

// File: tb/tb_ysyx_22040125_axi_master.sv
// Directed bench for ysyx_22040125_axi_master with a reactive AXI slave model and response scoreboard.
module tb_ysyx_22040125_axi_master;

`ifdef YSYX_22040125_AXI_RESP_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_wen = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_size = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic [3:0]  arid, awid, wid;
  logic [31:0] araddr, awaddr;
  logic [7:0]  arlen, awlen, wstrb;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic [3:0]  arcache, awcache;
  logic        arvalid, rready, awvalid, wvalid, wlast, bready;
  logic [63:0] wdata;
  logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b1, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [3:0]  rid = '0, bid = '0;
  logic [1:0]  rresp = '0, bresp = '0;
  logic [63:0] rdata = '0;

  ysyx_22040125_axi_master #(.AXI_ID(4'd0), .AXI_PROT(3'b000)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Slave behaviour knobs, set by the directed sequence
  int          ar_wait = 0, aw_wait = 0, w_wait = 0, r_wait = 0;
  logic [63:0] r_data = '0;
  logic [1:0]  r_resp = '0, b_resp = '0;
  logic [3:0]  r_id = '0, b_id = '0;

  // Expected channel contents of the transaction currently in flight
  logic [31:0] exp_addr = '0;
  logic [2:0]  exp_size = '0;
  logic [63:0] exp_wdata = '0;
  logic [7:0]  exp_wstrb = '0;

  int   ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0;
  logic r_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0;

  // Slave reacts on the falling edge; a ready/valid it raised last negedge has handshaken since.
  always @(negedge aclk) begin
    if (!aresetn) begin
      arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      r_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0;
    end else begin
      if (rvalid) rvalid = 1'b0;
      if (arready) begin
        arready = 1'b0; ar_cnt = 0; r_pend = 1'b1; r_cnt = 0;
      end else if (arvalid) begin
        chk("araddr", 64'(araddr), 64'(exp_addr));
        chk("arsize", 64'(arsize), 64'(exp_size));
        if (ar_cnt >= ar_wait) begin
          chk("ar_const", 64'({arlen, arburst, arlock, arcache, arid, arprot}),
              64'({8'd0, 2'b01, 2'b00, 4'd0, 4'd0, 3'd0}));
          arready = 1'b1;
        end else ar_cnt++;
      end
      if (r_pend) begin
        if (r_cnt >= r_wait) begin
          rvalid = 1'b1; rdata = r_data; rresp = r_resp; rid = r_id; r_pend = 1'b0;
        end else r_cnt++;
      end

      if (bvalid) bvalid = 1'b0;
      if (awready) begin
        awready = 1'b0; aw_cnt = 0; aw_got = 1'b1;
      end else if (awvalid) begin
        chk("awaddr", 64'(awaddr), 64'(exp_addr));
        chk("awsize", 64'(awsize), 64'(exp_size));
        if (aw_cnt >= aw_wait) begin
          chk("aw_const", 64'({awlen, awburst, awlock, awcache, awid, awprot}),
              64'({8'd0, 2'b01, 2'b00, 4'd0, 4'd0, 3'd0}));
          awready = 1'b1;
        end else aw_cnt++;
      end
      if (wready) begin
        wready = 1'b0; w_cnt = 0; w_got = 1'b1;
      end else if (wvalid) begin
        chk("wdata", wdata, exp_wdata);
        chk("wstrb_wlast_wid", 64'({wstrb, wlast, wid}), 64'({exp_wstrb, 1'b1, 4'd0}));
        if (w_cnt >= w_wait) wready = 1'b1;
        else w_cnt++;
      end
      if (aw_got && w_got) begin
        bvalid = 1'b1; bid = b_id; bresp = b_resp; aw_got = 1'b0; w_got = 1'b0;
      end
    end
  end

  typedef struct {
    bit          rd;
    logic [63:0] data;
    bit          err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;
  int   last_rsp_cyc = 0;
  int   last_acc_cyc = 0;
  logic prev_rv = 1'b0;

  always @(negedge aclk) begin
    if (aresetn && rsp_valid) begin
      chk("rsp_one_cycle", 64'(prev_rv), 64'd0);
      chk("rsp_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        got_e = sb.pop_front();
        chk("rsp_err", 64'(rsp_err), 64'(got_e.err));
        if (got_e.rd) chk("rsp_rdata", rsp_rdata, got_e.data);
        if (got_e.lat > 0) chk("rsp_latency", 64'(cyc - got_e.acc), 64'(got_e.lat));
      end
      last_rsp_cyc = cyc;
    end
    prev_rv = rsp_valid;
  end

  task automatic issue(input bit wen, input logic [31:0] addr, input logic [2:0] size,
                       input logic [63:0] wd, input logic [7:0] ws,
                       input logic [63:0] erd, input bit eerr, input int lat);
    int waits;
    exp_t e;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
    req_wdata = wd; req_wstrb = ws;
    waits = 0;
    while (req_ready !== 1'b1 && waits < 80) begin
      tick();
      waits++;
    end
    chk("accept_in_time", 64'(waits < 80), 64'd1);
    if (waits < 80) begin
      e.rd = !wen; e.data = erd; e.err = eerr; e.acc = cyc; e.lat = lat;
      sb.push_back(e);
      exp_addr = addr; exp_size = size; exp_wdata = wd; exp_wstrb = ws;
      last_acc_cyc = cyc;
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    chk("rsp_in_time", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_valids", 64'({arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err}), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    aresetn = 1'b1;
    chk("release_req_ready", 64'(req_ready), 64'd0);
    tick();
    chk("post_release_req_ready", 64'(req_ready), 64'd1);

    // Zero-wait read
    r_data = 64'h1122_3344_5566_7788;
    issue(1'b0, 32'h8000_0000, 3'd3, '0, '0, 64'h1122_3344_5566_7788, 1'b0, 3);
    wait_idle();
    repeat (2) tick();
    chk("rdata_held", rsp_rdata, 64'h1122_3344_5566_7788);

    // Write with AW late by three cycles, W immediate
    aw_wait = 3;
    issue(1'b1, 32'h8000_0008, 3'd3, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, '0, 1'b0, 6);
    chk("wr_c1", 64'({awvalid, wvalid, bready}), 64'b110);
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("wr_aw_pending", 64'({awvalid, wvalid, bready}), 64'b100);
    end
    tick();
    chk("wr_b_phase", 64'({awvalid, wvalid, bready}), 64'b001);
    wait_idle();
    chk("rdata_held_after_wr", rsp_rdata, 64'h1122_3344_5566_7788);

    // Write with W late, AW immediate
    aw_wait = 0; w_wait = 2;
    issue(1'b1, 32'h8000_0010, 3'd2, 64'h0000_0000_A5A5_5A5A, 8'h0F, '0, 1'b0, 5);
    wait_idle();
    w_wait = 0;

    // Stalled AR with a second request waiting behind it
    ar_wait = 5; r_data = 64'h0123_4567_89AB_CDEF;
    issue(1'b0, 32'h8000_0100, 3'd3, '0, '0, 64'h0123_4567_89AB_CDEF, 1'b0, 8);
    issue(1'b0, 32'h8000_0200, 3'd2, '0, '0, 64'h0123_4567_89AB_CDEF, 1'b0, 8);
    chk("second_accept_after_rsp", 64'(last_acc_cyc), 64'(last_rsp_cyc + 1));
    wait_idle();
    ar_wait = 0;

    // Reset while waiting in RD_R
    r_wait = 10;
    issue(1'b0, 32'h8000_0300, 3'd3, '0, '0, '0, 1'b0, 0);
    for (int n = 0; n < 20 && rready !== 1'b1; n++) tick();
    chk("reached_rd_r", 64'(rready), 64'd1);
    aresetn = 1'b0;
    tick();
    sb.delete();
    chk("abort_valids", 64'({arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err}), 64'd0);
    chk("abort_req_ready", 64'(req_ready), 64'd0);
    chk("abort_rdata", rsp_rdata, 64'd0);
    r_wait = 0;
    aresetn = 1'b1;
    chk("abort_release_req_ready", 64'(req_ready), 64'd0);
    tick();
    chk("abort_post_req_ready", 64'(req_ready), 64'd1);

    // Error responses
    r_resp = 2'b10; r_data = 64'hFEED_FACE_0BAD_F00D;
    issue(1'b0, 32'h8000_0400, 3'd3, '0, '0, 64'hFEED_FACE_0BAD_F00D, CHK_EN, 3);
    wait_idle();
    r_resp = 2'b00; b_id = 4'd5;
    issue(1'b1, 32'h8000_0408, 3'd1, 64'h0000_0000_0000_BEEF, 8'h03, '0, CHK_EN, 3);
    wait_idle();
    b_id = 4'd0;
    r_data = 64'h5555_AAAA_3333_CCCC;
    issue(1'b0, 32'h8000_0410, 3'd0, '0, '0, 64'h5555_AAAA_3333_CCCC, 1'b0, 3);
    wait_idle();

    // Read then write back-to-back with req_valid held
    r_data = 64'h0F0F_F0F0_1234_4321;
    issue(1'b0, 32'h8000_0500, 3'd3, '0, '0, 64'h0F0F_F0F0_1234_4321, 1'b0, 3);
    issue(1'b1, 32'h8000_0508, 3'd3, 64'h7777_8888_9999_0000, 8'hF0, '0, 1'b0, 3);
    chk("b2b_write_accept", 64'(last_acc_cyc), 64'(last_rsp_cyc + 1));
    wait_idle();
    chk("b2b_rdata_held", rsp_rdata, 64'h0F0F_F0F0_1234_4321);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
